// File: rtl/keypad_pkg.sv
// Shared key codes, entry-state encoding and defaults for keypad entry.
// Imported by keypad_code_entry and keypad_idle_timer.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR      = 4'hE;
    localparam logic [3:0] KEY_HASH      = 4'hF;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    localparam int unsigned KP_MAX_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        FULL
    } entry_state_e;

endpackage

// File: rtl/keypad_idle_timer.sv
// Loadable count-up idle timer; expire_o marks the last idle cycle.
// Built only when KEYPAD_ENTRY_TIMEOUT_EN is defined.
module keypad_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    import keypad_pkg::*;

    localparam int unsigned W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

    // Count while enabled; any key or expiry restarts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_code_entry.sv
// Assembles keypad digits into a BCD entry; '#' commits, '*' deletes.
// Optional idle timeout: define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_code_entry
    import keypad_pkg::*;
#(
    parameter int unsigned MAX_DIGITS     = KP_MAX_DIGITS,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic [4*MAX_DIGITS-1:0] entry_bcd,
    output logic [2:0]              digit_count,
    output logic                    code_valid,
    output logic [4*MAX_DIGITS-1:0] code_value,
    output logic [2:0]              code_len,
    output logic                    overflow,
    output logic                    empty_commit
);

    localparam int unsigned W = 4 * MAX_DIGITS;
    localparam logic [2:0]  MAXC = 3'(MAX_DIGITS);

    entry_state_e state_q, state_d;
    logic [W-1:0] entry_q, entry_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [W-1:0] val_q, val_d;
    logic [2:0]   len_q, len_d;
    logic         cv_q, cv_d;
    logic         ov_q, ov_d;
    logic         ec_q, ec_d;
    logic         expire;
    logic         is_digit;
    logic         is_star;
    logic         is_hash;

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    keypad_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en_i     (state_q != IDLE),
        .clr_i    (key_valid),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign is_digit = (key_code <= KEY_DIGIT_MAX);
    assign is_star  = (key_code == KEY_STAR);
    assign is_hash  = (key_code == KEY_HASH);

    // Next-state decode: keys take priority over idle expiry.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        len_d   = len_q;
        cv_d    = 1'b0;
        ov_d    = 1'b0;
        ec_d    = 1'b0;
        if (key_valid) begin
            unique case (1'b1)
                is_digit: begin
                    if (state_q == FULL) begin
                        ov_d = 1'b1;
                    end else begin
                        entry_d = (entry_q << 4) | W'(key_code);
                        cnt_d   = cnt_q + 3'd1;
                        state_d = (cnt_d == MAXC) ? FULL : ENTRY;
                    end
                end
                is_star: begin
                    if (state_q != IDLE) begin
                        entry_d = entry_q >> 4;
                        cnt_d   = cnt_q - 3'd1;
                        state_d = (cnt_d == 3'd0) ? IDLE : ENTRY;
                    end
                end
                is_hash: begin
                    if (state_q == IDLE) begin
                        ec_d = 1'b1;
                    end else begin
                        val_d   = entry_q;
                        len_d   = cnt_q;
                        cv_d    = 1'b1;
                        entry_d = '0;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (expire) begin
            entry_d = '0;
            cnt_d   = 3'd0;
            state_d = IDLE;
        end
    end

    // State, entry buffer, committed code and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            entry_q <= '0;
            cnt_q   <= 3'd0;
            val_q   <= '0;
            len_q   <= 3'd0;
            cv_q    <= 1'b0;
            ov_q    <= 1'b0;
            ec_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            len_q   <= len_d;
            cv_q    <= cv_d;
            ov_q    <= ov_d;
            ec_q    <= ec_d;
        end
    end

    assign entry_bcd    = entry_q;
    assign digit_count  = cnt_q;
    assign code_value   = val_q;
    assign code_len     = len_q;
    assign code_valid   = cv_q;
    assign overflow     = ov_q;
    assign empty_commit = ec_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboard bench for keypad_code_entry: driver queues hand-computed
// responses per key, monitor compares them the cycle after each key.
module tb_keypad_code_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic        code_valid;
    logic [15:0] code_value;
    logic [2:0]  code_len;
    logic        overflow;
    logic        empty_commit;

    typedef struct {
        string       tag;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic        cv;
        logic [15:0] val;
        logic [2:0]  len;
        logic        ov;
        logic        ec;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;
    logic kv_d;

    keypad_code_entry #(
        .MAX_DIGITS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .entry_bcd    (entry_bcd),
        .digit_count  (digit_count),
        .code_valid   (code_valid),
        .code_value   (code_value),
        .code_len     (code_len),
        .overflow     (overflow),
        .empty_commit (empty_commit)
    );

    always #5 clk = ~clk;

    // Marks the cycles whose outputs answer a key event.
    always @(posedge clk) kv_d <= key_valid && !reset;

    // Monitor: pop and compare on every key response; else no pulses.
    always @(negedge clk) begin
        if (kv_d) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: response with empty queue");
            end else begin
                e = sb.pop_front();
                if (entry_bcd !== e.entry || digit_count !== e.cnt ||
                    code_valid !== e.cv || code_value !== e.val ||
                    code_len !== e.len || overflow !== e.ov ||
                    empty_commit !== e.ec) begin
                    fails++;
                    $display("FAIL %s: got e=%h n=%0d cv=%b v=%h l=%0d ov=%b ec=%b, need e=%h n=%0d cv=%b v=%h l=%0d ov=%b ec=%b",
                        e.tag, entry_bcd, digit_count, code_valid,
                        code_value, code_len, overflow, empty_commit,
                        e.entry, e.cnt, e.cv, e.val, e.len, e.ov, e.ec);
                end
            end
        end else if (!reset) begin
            checks++;
            if (code_valid || overflow || empty_commit) begin
                fails++;
                $display("FAIL spurious_pulse: cv=%b ov=%b ec=%b, need 000",
                    code_valid, overflow, empty_commit);
            end
        end
    end

    task automatic press(input string tag, input logic [3:0] k,
                         input logic [15:0] en, input logic [2:0] n,
                         input logic cv, input logic [15:0] v,
                         input logic [2:0] l, input logic ov,
                         input logic ec);
        exp_t x;
        x.tag = tag; x.entry = en; x.cnt = n; x.cv = cv;
        x.val = v; x.len = l; x.ov = ov; x.ec = ec;
        sb.push_back(x);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [15:0] en,
                               input logic [2:0] n, input logic [15:0] v,
                               input logic [2:0] l);
        checks++;
        if (entry_bcd !== en || digit_count !== n ||
            code_value !== v || code_len !== l) begin
            fails++;
            $display("FAIL %s: got e=%h n=%0d v=%h l=%0d, need e=%h n=%0d v=%h l=%0d",
                tag, entry_bcd, digit_count, code_value, code_len,
                en, n, v, l);
        end
    endtask

    task automatic do_reset();
        key_valid = 1'b0;
        key_code  = 4'h0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_state("reset_state", 16'h0000, 3'd0, 16'h0000, 3'd0);

        press("d1",   4'd1, 16'h0001, 3'd1, 0, 16'h0000, 3'd0, 0, 0);
        press("d2",   4'd2, 16'h0012, 3'd2, 0, 16'h0000, 3'd0, 0, 0);
        press("d3",   4'd3, 16'h0123, 3'd3, 0, 16'h0000, 3'd0, 0, 0);
        press("d4",   4'd4, 16'h1234, 3'd4, 0, 16'h0000, 3'd0, 0, 0);
        press("h1",   4'hF, 16'h0000, 3'd0, 1, 16'h1234, 3'd4, 0, 0);
        press("d5",   4'd5, 16'h0005, 3'd1, 0, 16'h1234, 3'd4, 0, 0);
        press("d6",   4'd6, 16'h0056, 3'd2, 0, 16'h1234, 3'd4, 0, 0);
        press("st1",  4'hE, 16'h0005, 3'd1, 0, 16'h1234, 3'd4, 0, 0);
        press("d7",   4'd7, 16'h0057, 3'd2, 0, 16'h1234, 3'd4, 0, 0);
        press("h2",   4'hF, 16'h0000, 3'd0, 1, 16'h0057, 3'd2, 0, 0);
        idle(2);

        press("n9a",  4'd9, 16'h0009, 3'd1, 0, 16'h0057, 3'd2, 0, 0);
        press("n9b",  4'd9, 16'h0099, 3'd2, 0, 16'h0057, 3'd2, 0, 0);
        press("n9c",  4'd9, 16'h0999, 3'd3, 0, 16'h0057, 3'd2, 0, 0);
        press("n9d",  4'd9, 16'h9999, 3'd4, 0, 16'h0057, 3'd2, 0, 0);
        press("ovf",  4'd8, 16'h9999, 3'd4, 0, 16'h0057, 3'd2, 1, 0);
        idle(1);
        press("del4", 4'hE, 16'h0999, 3'd3, 0, 16'h0057, 3'd2, 0, 0);
        press("del3", 4'hE, 16'h0099, 3'd2, 0, 16'h0057, 3'd2, 0, 0);
        press("del2", 4'hE, 16'h0009, 3'd1, 0, 16'h0057, 3'd2, 0, 0);
        press("del1", 4'hE, 16'h0000, 3'd0, 0, 16'h0057, 3'd2, 0, 0);
        press("del0", 4'hE, 16'h0000, 3'd0, 0, 16'h0057, 3'd2, 0, 0);
        press("emp",  4'hF, 16'h0000, 3'd0, 0, 16'h0057, 3'd2, 0, 1);
        press("keyB", 4'hB, 16'h0000, 3'd0, 0, 16'h0057, 3'd2, 0, 0);
        press("d0",   4'd0, 16'h0000, 3'd1, 0, 16'h0057, 3'd2, 0, 0);
        press("keyA", 4'hA, 16'h0000, 3'd1, 0, 16'h0057, 3'd2, 0, 0);
        press("h3",   4'hF, 16'h0000, 3'd0, 1, 16'h0000, 3'd1, 0, 0);
        idle(2);

        press("r3",   4'd3, 16'h0003, 3'd1, 0, 16'h0000, 3'd1, 0, 0);
        press("r1",   4'd1, 16'h0031, 3'd2, 0, 16'h0000, 3'd1, 0, 0);
        key_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_state("mid_reset", 16'h0000, 3'd0, 16'h0000, 3'd0);
        idle(2);

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        press("t2",   4'd2, 16'h0002, 3'd1, 0, 16'h0000, 3'd0, 0, 0);
        idle(15);
        check_state("pre_expiry", 16'h0002, 3'd1, 16'h0000, 3'd0);
        idle(1);
        check_state("expired", 16'h0000, 3'd0, 16'h0000, 3'd0);
        press("u2",   4'd2, 16'h0002, 3'd1, 0, 16'h0000, 3'd0, 0, 0);
        idle(15);
        press("u3",   4'd3, 16'h0023, 3'd2, 0, 16'h0000, 3'd0, 0, 0);
        idle(1);
        check_state("key_wins", 16'h0023, 3'd2, 16'h0000, 3'd0);
        idle(15);
        check_state("expired2", 16'h0000, 3'd0, 16'h0000, 3'd0);
`else
        press("t2",   4'd2, 16'h0002, 3'd1, 0, 16'h0000, 3'd0, 0, 0);
        idle(40);
        check_state("held", 16'h0002, 3'd1, 16'h0000, 3'd0);
`endif

        idle(2);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d entries, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
            checks, fails);
        $finish;
    end

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
- Downstream of the 4x4 matrix keypad scanner.
- Consumes one-cycle key events (4-bit key code plus strobe) and assembles up to 4 decimal digits into a BCD entry buffer.
- '#' commits the entry as a code word for the lock/display logic; '*' deletes the last digit.
- Provides the live entry for the 7-segment display and a one-cycle commit pulse.

Parameters:
- MAX_DIGITS, 4, entry depth in digits (buffer width 4*MAX_DIGITS).
- TIMEOUT_CYCLES, 50000000, idle cycles before a partial entry is discarded (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- key_valid  input  1  one-cycle strobe from scanner on key release.
- key_code  input  4  0-9 digit, 4'hE '*', 4'hF '#', 4'hA-4'hD ignored.
- entry_bcd  output  4*MAX_DIGITS  live entry, right-aligned, newest digit in [3:0].
- digit_count  output  3  digits currently held (0..MAX_DIGITS).
- code_valid  output  1  one-cycle pulse on commit.
- code_value  output  4*MAX_DIGITS  committed entry; held until next commit.
- code_len  output  3  digit count of committed entry; held with code_value.
- overflow  output  1  one-cycle pulse: digit pressed while buffer full.
- empty_commit  output  1  one-cycle pulse: '#' pressed with zero digits.

Behaviour:
- Reset (synchronous, active-high): entry_bcd=0, digit_count=0, code_value=0, code_len=0, all pulses 0, state=IDLE, timer=0.
- key_code is sampled only in cycles where key_valid=1. Every response registers one cycle after the key_valid cycle.
- FSM states:
  - IDLE: digit_count=0.
  - ENTRY: 0<count<MAX_DIGITS.
  - FULL: count=MAX_DIGITS.
- Digit key (0-9):
  - IDLE/ENTRY: entry_bcd <= {entry_bcd[4*MAX_DIGITS-5:0], key_code}, count+1. Move to FULL when count reaches MAX_DIGITS, else ENTRY.
  - FULL: entry unchanged; overflow=1 for one cycle.
- '*' key:
  - ENTRY/FULL: entry_bcd <= entry_bcd >> 4, count-1. Move to IDLE if count becomes 0, else ENTRY.
  - IDLE: no effect, no pulse.
- '#' key:
  - ENTRY/FULL: code_value<=entry_bcd, code_len<=digit_count, code_valid=1 for one cycle, entry_bcd<=0, count<=0, state<=IDLE.
  - IDLE: empty_commit=1 for one cycle; code_value and code_len unchanged.
- Keys A-D: ignored entirely; the idle timer is still reloaded.
- key_valid held high for consecutive cycles: each cycle is a separate event.
- No back-pressure: a new key_valid in the cycle after a commit is processed normally.
- code_value and code_len persist across later entries; only a commit or reset changes them.
- Reset asserted mid-entry: partial entry is discarded; code_valid is not asserted.

Optional Feature:
- Macro: KEYPAD_ENTRY_TIMEOUT_EN.
- With the macro defined:
  - An idle counter increments every cycle while state!=IDLE and reloads to 0 on any key_valid.
  - When the counter reaches TIMEOUT_CYCLES-1, entry_bcd and count clear and state goes to IDLE, with no code_valid pulse.
  - If key_valid coincides with expiry, the key wins: it is processed normally and the counter reloads.
  - Counter width: $clog2(TIMEOUT_CYCLES).
- Without the macro: no counter is built; a partial entry is held indefinitely.

Decomposition:
- Package keypad_pkg holds:
  - KEY_STAR=4'hE, KEY_HASH=4'hF, KEY_DIGIT_MAX=4'd9.
  - The entry-state enum {IDLE, ENTRY, FULL}.
  - A default for MAX_DIGITS.
- One natural sub-module: keypad_idle_timer (loadable count-up timer with expiry pulse), instantiated only under KEYPAD_ENTRY_TIMEOUT_EN.

Test Plan:
- Reset, then keys 1,2,3,4,'#' -> entry_bcd steps 0x0001,0x0012,0x0123,0x1234. Cycle after '#': code_valid=1, code_value=0x1234, code_len=4, entry_bcd=0, digit_count=0.
- Keys 5,6,'*',7,'#' -> code_value=0x0057, code_len=2, single code_valid pulse.
- Keys 9,9,9,9,8 -> 5th key gives overflow=1 for one cycle; entry_bcd stays 0x9999, digit_count=4.
- '#' from IDLE -> empty_commit=1 for one cycle, code_valid=0, code_value retains prior 0x0057. Key 4'hB -> no output change.
- Keys 3,1 then reset for one cycle -> entry_bcd=0, digit_count=0, code_value=0, no code_valid.
- With KEYPAD_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Key 2 then 16 idle cycles -> entry cleared to IDLE, no code_valid.
  - Key 2, then key 3 exactly at expiry -> entry_bcd=0x0023 retained.
